sketch_draw_ctrl: RTL
=====================

// Module: sketch_draw_ctrl
// PURPOSE
//  Sequences all writes into the image frame register (ports draw / draw_image) from user pen controls.
//  Keeps a wrapping cursor and turns pen/erase/clear requests into single-cycle read-modify-write commits.
//  Reads image back from the register and arbitrates clear against pen writes, so at most one commit is in flight.
// PARAMETERS
//  WIDTH        16  pixels in the image register; must match the image instance width
//  POS_W        4   cursor width; 2**POS_W >= WIDTH
//  GAP_CYCLES   2   idle cycles after each commit before re-evaluating; legal range 1..15
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  reset        in   1      synchronous, active-high
//  move_left    in   1      one-cycle pulse: cursor - 1
//  move_right   in   1      one-cycle pulse: cursor + 1
//  pen_down     in   1      level: write the pixel under the cursor
//  erase        in   1      level: pen writes 0 instead of 1
//  clear_req    in   1      one-cycle pulse: zero the whole image
//  image        in   WIDTH  current image register contents (readback)
//  draw         out  1      one-cycle write strobe to the image register
//  draw_image   out  WIDTH  value to write; stable whenever draw=1
//  cursor       out  POS_W  current pixel index
//  busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset values:
//   - draw=0, draw_image=0, cursor=0, busy=0, state=IDLE, clear_pending=0.
//   - Reset mid-operation aborts at that edge; no draw pulse is issued afterwards.
//  States: IDLE, CALC, COMMIT, CLEAR, GAP.
//  IDLE: one action per cycle, priority clear > pen > move; lower-priority requests that cycle are dropped.
//   - clear_req | clear_pending -> CLEAR; clear_pending <= 0.
//   - Else pen_down && image[cursor] != ~erase -> CALC; tgt_pos <= cursor; tgt_val <= ~erase.
//   - Else move: right wraps WIDTH-1 -> 0; left wraps 0 -> WIDTH-1; both pulses together = no move.
//   - pen_down with the pixel already at its target value: no write; moves are still honoured.
//  CALC (1 cycle):
//   - draw_image <= image with bit tgt_pos forced to tgt_val; all other bits copied from image.
//   - Next state COMMIT.
//  COMMIT (1 cycle): draw=1; draw_image unchanged; next state GAP.
//  CLEAR (1 cycle): draw=1 with draw_image=0; draw_image is loaded with 0 on entry; next state GAP.
//  GAP:
//   - Counter loads GAP_CYCLES on entry, decrements each cycle, returns to IDLE after GAP_CYCLES cycles.
//   - Lets the image readback settle before re-evaluation.
//  Outside IDLE:
//   - move/pen/erase are ignored, not queued.
//   - clear_req sets clear_pending, which is serviced in the first IDLE cycle.
//  Latency, trigger sampled in IDLE at cycle 0:
//   - pen: CALC cycle 1, draw=1 cycle 2, GAP cycles 3..2+GAP_CYCLES, IDLE at 3+GAP_CYCLES.
//   - clear: draw=1 cycle 1, IDLE at 2+GAP_CYCLES.
//  draw is never high on two consecutive cycles.
//  draw_image changes only on CALC and CLEAR entry.
// TESTING (WIDTH=4, POS_W=2, GAP_CYCLES=2, bench models the image register)
//  1. Reset -> draw=0, draw_image=0000, cursor=0, busy=0; hold 5 cycles with no inputs -> no draw.
//  2. Five move_right pulses -> cursor=1 (wrapped); then move_left at cursor 0 -> 3;
//     both pulses in one cycle -> unchanged.
//  3. image=0000, cursor=2, pen_down=1, erase=0 -> draw=1 at cycle 2 with draw_image=0100, busy for 4 cycles;
//     held pen_down then gives no further draw.
//  4. image=0110, cursor=1, pen_down=1, erase=1 -> single draw with draw_image=0100.
//  5. clear_req during GAP with pen_down=1 -> clear serviced first: draw with 0000;
//     then after GAP the pen write follows at the cursor.
//  6. reset asserted during CALC -> no draw pulse, cursor=0, busy=0 next cycle,
//     image register unchanged.

Source files
------------

// File: rtl/sketch_draw_ctrl_if.sv
// Image register bus: the controller reads the frame back on `image` and
// writes it with a one-cycle `draw` strobe carrying `draw_image`.
interface sketch_draw_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             draw;
    logic [WIDTH-1:0] draw_image;
    logic [WIDTH-1:0] image;

    // Controller side
    modport master (
        output draw,
        output draw_image,
        input  image
    );

    // Image register side
    modport slave (
        input  draw,
        input  draw_image,
        output image
    );
endinterface

// File: rtl/sketch_draw_ctrl.sv
// Pen/erase/clear sequencer for a single-row image register. Keeps a wrapping
// cursor and turns each request into one read-modify-write commit, followed by
// a settle gap so the readback is current before the next decision.
module sketch_draw_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned POS_W      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_move_left,
    input  logic                      i_move_right,
    input  logic                      i_pen_down,
    input  logic                      i_erase,
    input  logic                      i_clear_req,
    sketch_draw_ctrl_if.master        io_bus,
    output logic [POS_W-1:0]          o_cursor,
    output logic                      o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StCommit,
        StClear,
        StGap
    } state_e;

    localparam logic [POS_W-1:0] LastPos = POS_W'(WIDTH - 1);
    localparam logic [3:0]       GapLoad = 4'(GAP_CYCLES);

    state_e           r_state, w_state_nxt;
    logic [POS_W-1:0] r_cursor, w_cursor_nxt;
    logic [POS_W-1:0] r_tgt_pos, w_tgt_pos_nxt;
    logic             r_tgt_val, w_tgt_val_nxt;
    logic [WIDTH-1:0] r_draw_image, w_draw_image_nxt;
    logic             r_clear_pending, w_clear_pending_nxt;
    logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic [WIDTH-1:0] w_merged;
    logic             w_pen_write;

    // Pen only needs a commit when the pixel differs from the value it would write.
    assign w_pen_write = i_pen_down && (io_bus.image[r_cursor] != ~i_erase);

    // Readback with the target pixel forced; all other pixels preserved.
    always_comb begin
        w_merged             = io_bus.image;
        w_merged[r_tgt_pos]  = r_tgt_val;
    end

    // Next-state and datapath decisions; IDLE priority is clear > pen > move.
    always_comb begin
        w_state_nxt         = r_state;
        w_cursor_nxt        = r_cursor;
        w_tgt_pos_nxt       = r_tgt_pos;
        w_tgt_val_nxt       = r_tgt_val;
        w_draw_image_nxt    = r_draw_image;
        w_clear_pending_nxt = r_clear_pending;
        w_gap_cnt_nxt       = r_gap_cnt;

        // A clear arriving while busy is remembered; other requests are dropped.
        if (r_state != StIdle && i_clear_req) begin
            w_clear_pending_nxt = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (i_clear_req || r_clear_pending) begin
                    w_state_nxt         = StClear;
                    w_clear_pending_nxt = 1'b0;
                    w_draw_image_nxt    = '0;
                end else if (w_pen_write) begin
                    w_state_nxt   = StCalc;
                    w_tgt_pos_nxt = r_cursor;
                    w_tgt_val_nxt = ~i_erase;
                end else if (i_move_right && !i_move_left) begin
                    w_cursor_nxt = (r_cursor == LastPos) ? '0 : r_cursor + 1'b1;
                end else if (i_move_left && !i_move_right) begin
                    w_cursor_nxt = (r_cursor == '0) ? LastPos : r_cursor - 1'b1;
                end
            end
            StCalc: begin
                w_draw_image_nxt = w_merged;
                w_state_nxt      = StCommit;
            end
            StCommit, StClear: begin
                w_state_nxt   = StGap;
                w_gap_cnt_nxt = GapLoad;
            end
            StGap: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any commit in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_cursor        <= '0;
            r_tgt_pos       <= '0;
            r_tgt_val       <= 1'b0;
            r_draw_image    <= '0;
            r_clear_pending <= 1'b0;
            r_gap_cnt       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cursor        <= w_cursor_nxt;
            r_tgt_pos       <= w_tgt_pos_nxt;
            r_tgt_val       <= w_tgt_val_nxt;
            r_draw_image    <= w_draw_image_nxt;
            r_clear_pending <= w_clear_pending_nxt;
            r_gap_cnt       <= w_gap_cnt_nxt;
        end
    end

    // The strobe is decoded from state, so it can never span two cycles.
    assign io_bus.draw       = (r_state == StCommit) || (r_state == StClear);
    assign io_bus.draw_image = r_draw_image;
    assign o_cursor          = r_cursor;
    assign o_busy            = (r_state != StIdle);

endmodule
